fetch_unit: RTL

Instruction-fetch and program-counter stage sitting directly upstream of the control decoder. It owns the PC, issues requests to instruction memory over a req/ack handshake, and holds the fetched word stable in an instruction register while decode/execute run. When execute completes, it takes back `pc_select`, the ALU result, the immediate and rv1, and computes the next PC. It flags misaligned control-flow targets and counts retired instructions.

---
 rtl/core_pkg.sv | 19 +
 rtl/next_pc_calc.sv | 41 ++++
 rtl/fetch_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: next-PC select codes, fetch FSM states and
// default datapath width, common to the fetch stage and the decoder.
package core_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] PCS_SEQ   = 4'b0000;
    localparam logic [3:0] PCS_BR_Z  = 4'b0001;
    localparam logic [3:0] PCS_BR_NZ = 4'b0010;
    localparam logic [3:0] PCS_JALR  = 4'b0111;
    localparam logic [3:0] PCS_JAL   = 4'b1000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for branches and jumps, with
// a misalignment flag for control-flow targets.
module next_pc_calc
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] pc,
    input  logic [3:0]      pc_select,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rv1,
    output logic [XLEN-1:0] npc,
    output logic            misaligned
);

    logic [XLEN-1:0] seq;
    logic [XLEN-1:0] rel;
    logic [XLEN-1:0] reg_tgt;
    logic            zero;

    assign seq     = pc + XLEN'(4);
    assign rel     = pc + imm;
    assign reg_tgt = (rv1 + imm) & ~XLEN'(1);
    assign zero    = (alu_result == '0);

    always_comb begin
        npc = seq;
        case (pc_select)
            PCS_SEQ:   npc = seq;
            PCS_BR_Z:  npc = zero ? rel : seq;
            PCS_BR_NZ: npc = zero ? seq : rel;
            PCS_JALR:  npc = reg_tgt;
            PCS_JAL:   npc = rel;
            default:   npc = seq;
        endcase
    end

    assign misaligned = (npc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Fetch/PC stage: owns the PC, fetches over req/ack, holds the
// instruction register and counts retired instructions.
module fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic [XLEN-1:0] iaddr,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [31:0]     idata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            exec_done,
    input  logic [3:0]      pc_select,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rv1,
    output logic            fault,
    output logic [63:0]     instret
);

    fetch_state_t    state;
    logic [XLEN-1:0] npc;
    logic            misaligned;

    next_pc_calc #(
        .XLEN(XLEN)
    ) u_npc (
        .pc         (pc),
        .pc_select  (pc_select),
        .alu_result (alu_result),
        .imm        (imm),
        .rv1        (rv1),
        .npc        (npc),
        .misaligned (misaligned)
    );

    assign iaddr    = pc;
    assign pc_plus4 = pc + XLEN'(4);

    // imem_req is registered so it only rises the cycle after reset
    // release and stays put with iaddr until the ack arrives.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= FETCH;
            pc          <= RESET_ADDR;
            imem_req    <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
            instret     <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_req && imem_ack) begin
                        instr       <= idata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= EXEC;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        instret     <= instret + 64'd1;
                        instr_valid <= 1'b0;
                        if (misaligned) begin
                            fault <= 1'b1;
                            state <= HALT;
                        end else begin
                            pc       <= npc;
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                HALT: begin
                    imem_req <= 1'b0;
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= HALT;
                end
            endcase
        end
    end

endmodule
